hpdcache_victim_sel_rt: RTL and testbench

// Runtime-configurable victim selector for the HPDcache miss/refill path.

---
 rtl/hpdcache_victim_sel_rt_if.sv | 41 ++++
 rtl/hpdcache_victim_sel_rt.sv | 132 +++++++++++++
 tb/tb_hpdcache_victim_sel_rt.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/hpdcache_victim_sel_rt_if.sv
// rtl/hpdcache_victim_sel_rt_if.sv - victim selector config, update and request/response bundle
interface hpdcache_victim_sel_rt_if #(
  parameter int WAYS = 4,
  parameter int SETS = 64
);
  localparam int SW = (SETS > 1) ? $clog2(SETS) : 1;

  logic [1:0]      cfg_mode_i;
  logic [WAYS-1:0] cfg_way_mask_i;

  logic            updt_i;
  logic [SW-1:0]   updt_set_i;
  logic [WAYS-1:0] updt_way_i;

  logic            sel_victim_i;
  logic [WAYS-1:0] sel_dir_valid_i;
  logic [WAYS-1:0] sel_dir_wback_i;
  logic [WAYS-1:0] sel_dir_dirty_i;
  logic [WAYS-1:0] sel_dir_fetch_i;
  logic [SW-1:0]   sel_victim_set_i;

  logic            sel_valid_o;
  logic [WAYS-1:0] sel_victim_way_o;
  logic            sel_none_o;

  modport master (
    output cfg_mode_i, cfg_way_mask_i,
    output updt_i, updt_set_i, updt_way_i,
    output sel_victim_i, sel_dir_valid_i, sel_dir_wback_i, sel_dir_dirty_i,
    output sel_dir_fetch_i, sel_victim_set_i,
    input  sel_valid_o, sel_victim_way_o, sel_none_o
  );

  modport slave (
    input  cfg_mode_i, cfg_way_mask_i,
    input  updt_i, updt_set_i, updt_way_i,
    input  sel_victim_i, sel_dir_valid_i, sel_dir_wback_i, sel_dir_dirty_i,
    input  sel_dir_fetch_i, sel_victim_set_i,
    output sel_valid_o, sel_victim_way_o, sel_none_o
  );
endinterface

// File: rtl/hpdcache_victim_sel_rt.sv
// rtl/hpdcache_victim_sel_rt.sv - runtime-configurable victim selector (random, PLRU, round-robin)
module hpdcache_victim_sel_rt #(
  parameter int                 WAYS      = 4,
  parameter int                 SETS      = 64,
  parameter int                 LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]  LFSR_SEED = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  hpdcache_victim_sel_rt_if.slave vs
);
  localparam int SW = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int WW = $clog2(WAYS);
  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400);

  localparam logic [1:0] MODE_RANDOM = 2'd0;
  localparam logic [1:0] MODE_RR     = 2'd2;

  logic [WAYS-1:0]   mru_q [SETS];
  logic [WW-1:0]     rr_q  [SETS];
  logic [LFSR_W-1:0] lfsr_q;

  logic              sel_valid_q;
  logic [WAYS-1:0]   sel_way_q;
  logic              sel_none_q;

  logic [WAYS-1:0]   elig, inv, clean, cand, pick;
  logic [WAYS-1:0]   mru_sel;
  logic [WW-1:0]     off, pick_idx, idx;
  logic              found, sel_go, same_set;
  logic [WAYS-1:0]   upd_a;
  logic              wr_a, wr_b;
  logic [LFSR_W-1:0] lfsr_nxt;

  function automatic logic [WAYS-1:0] mru_next(input logic [WAYS-1:0] old_v,
                                               input logic [WAYS-1:0] upd_v,
                                               input logic [WAYS-1:0] mask_v);
    logic [WAYS-1:0] m;
    m = old_v | upd_v;
    return ((m & mask_v) == mask_v) ? upd_v : m;
  endfunction

  always_comb begin
    elig     = vs.cfg_way_mask_i & ~vs.sel_dir_fetch_i;
    inv      = elig & ~vs.sel_dir_valid_i;
    clean    = elig & ~(vs.sel_dir_dirty_i & vs.sel_dir_wback_i);
    cand     = (clean != '0) ? clean : elig;
    mru_sel  = mru_q[vs.sel_victim_set_i];
    off      = (vs.cfg_mode_i == MODE_RANDOM) ? lfsr_q[WW-1:0] : rr_q[vs.sel_victim_set_i];
    pick_idx = '0;
    idx      = '0;
    found    = 1'b0;

    if (inv != '0) begin
      for (int i = 0; i < WAYS; i++) begin
        if (!found && inv[i]) begin
          found    = 1'b1;
          pick_idx = WW'(i);
        end
      end
    end else if (vs.cfg_mode_i == MODE_RANDOM || vs.cfg_mode_i == MODE_RR) begin
      // WW-bit addition wraps modulo WAYS since WAYS is a power of two
      for (int k = 0; k < WAYS; k++) begin
        idx = off + WW'(k);
        if (!found && cand[idx]) begin
          found    = 1'b1;
          pick_idx = idx;
        end
      end
    end else begin
      for (int i = 0; i < WAYS; i++) begin
        if (!found && cand[i] && !mru_sel[i]) begin
          found    = 1'b1;
          pick_idx = WW'(i);
        end
      end
      for (int i = 0; i < WAYS; i++) begin
        if (!found && cand[i]) begin
          found    = 1'b1;
          pick_idx = WW'(i);
        end
      end
    end

    pick     = found ? (WAYS'(1) << pick_idx) : '0;
    sel_go   = vs.sel_victim_i && found;
    same_set = sel_go && (vs.sel_victim_set_i == vs.updt_set_i);
    upd_a    = (vs.updt_i ? vs.updt_way_i : '0) | (same_set ? pick : '0);
    wr_a     = (upd_a != '0);
    wr_b     = sel_go && !same_set;
    lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SETS; s++) begin
        mru_q[s] <= '0;
        rr_q[s]  <= '0;
      end
      lfsr_q      <= LFSR_SEED;
      sel_valid_q <= 1'b0;
      sel_way_q   <= '0;
      sel_none_q  <= 1'b0;
    end else begin
      if (wr_a) mru_q[vs.updt_set_i] <= mru_next(mru_q[vs.updt_set_i], upd_a, vs.cfg_way_mask_i);
      if (wr_b) mru_q[vs.sel_victim_set_i] <= mru_next(mru_q[vs.sel_victim_set_i], pick,
                                                       vs.cfg_way_mask_i);
      if (sel_go && vs.cfg_mode_i == MODE_RR) rr_q[vs.sel_victim_set_i] <= pick_idx + WW'(1);
      // The LFSR advances on every request regardless of the active policy
      if (vs.sel_victim_i) lfsr_q <= lfsr_nxt;
      sel_valid_q <= vs.sel_victim_i;
      sel_way_q   <= vs.sel_victim_i ? pick : '0;
      sel_none_q  <= vs.sel_victim_i && !found;
    end
  end

  assign vs.sel_valid_o      = sel_valid_q;
  assign vs.sel_victim_way_o = sel_way_q;
  assign vs.sel_none_o       = sel_none_q;

`ifndef HPDCACHE_ASSERT_OFF
  if ((WAYS < 2) || ((WAYS & (WAYS - 1)) != 0)) begin : g_ways_chk
    $error("WAYS must be a power of two >= 2");
  end
  if (LFSR_SEED == '0) begin : g_seed_chk
    $error("LFSR_SEED must be nonzero");
  end
  victim_onehot0_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    sel_valid_q |-> $onehot0(sel_way_q));
`endif
endmodule

// File: tb/tb_hpdcache_victim_sel_rt.sv
// tb/tb_hpdcache_victim_sel_rt.sv - randomized model-checked bench for hpdcache_victim_sel_rt
module tb_hpdcache_victim_sel_rt;
  logic clk;
  logic rst_ni;

  hpdcache_victim_sel_rt_if #(.WAYS(4), .SETS(64)) vif ();

  hpdcache_victim_sel_rt #(
    .WAYS(4), .SETS(64), .LFSR_W(16), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .vs    (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  mru_m [64];
  int          rr_m  [64];
  logic [15:0] lfsr_m;
  logic [3:0]  last_way;
  logic        last_none;
  int          way_cnt [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] touch(input logic [3:0] old_v, input logic [3:0] u,
                                       input logic [3:0] mask);
    logic [3:0] m;
    m = old_v | u;
    if ((m & mask) == mask) return u;
    return m;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      mru_m[s] = 4'b0;
      rr_m[s]  = 0;
    end
    lfsr_m = 16'hACE1;
  endtask

  // Applies the replacement rules to the inputs currently on the bus
  task automatic model_eval(output logic [3:0] ew, output logic en);
    logic [3:0] elig, inv, clean, cand, ua, mask;
    int idx, off, s, u, mode;
    idx  = -1;
    ew   = 4'b0;
    en   = 1'b0;
    s    = int'(vif.sel_victim_set_i);
    u    = int'(vif.updt_set_i);
    mode = int'(vif.cfg_mode_i);
    mask = vif.cfg_way_mask_i;
    if (vif.sel_victim_i) begin
      elig  = mask & ~vif.sel_dir_fetch_i;
      inv   = elig & ~vif.sel_dir_valid_i;
      clean = elig & ~(vif.sel_dir_dirty_i & vif.sel_dir_wback_i);
      cand  = (clean != 0) ? clean : elig;
      if (elig == 0) en = 1'b1;
      else if (inv != 0) idx = lowest(inv);
      else if (mode == 0 || mode == 2) begin
        off = (mode == 0) ? int'(lfsr_m % 16'd4) : rr_m[s];
        for (int k = 0; k < 4; k++) if (idx < 0 && cand[(off + k) % 4]) idx = (off + k) % 4;
      end else begin
        for (int i = 0; i < 4; i++) if (idx < 0 && cand[i] && !mru_m[s][i]) idx = i;
        if (idx < 0) idx = lowest(cand);
      end
      if (idx >= 0) ew = 4'(1 << idx);
      if (mode == 2 && idx >= 0) rr_m[s] = (idx + 1) % 4;
      lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end
    ua = vif.updt_i ? vif.updt_way_i : 4'b0;
    if (ew != 0 && s == u) ua = ua | ew;
    else if (ew != 0) mru_m[s] = touch(mru_m[s], ew, mask);
    if (ua != 0) mru_m[u] = touch(mru_m[u], ua, mask);
  endtask

  task automatic cycle(input string tag);
    logic [3:0] ew;
    logic en, req;
    req = vif.sel_victim_i;
    model_eval(ew, en);
    @(posedge clk);
    #1;
    check({tag, ":valid"}, 32'(vif.sel_valid_o), 32'(req));
    if (req) begin
      check({tag, ":way"},  32'(vif.sel_victim_way_o), 32'(ew));
      check({tag, ":none"}, 32'(vif.sel_none_o), 32'(en));
    end
    last_way  = vif.sel_victim_way_o;
    last_none = vif.sel_none_o;
  endtask

  task automatic set_req(input logic sel, input logic [1:0] mode, input int set,
                         input logic [3:0] valid, input logic [3:0] dw);
    vif.sel_victim_i     = sel;
    vif.cfg_mode_i       = mode;
    vif.sel_victim_set_i = 6'(set);
    vif.sel_dir_valid_i  = valid;
    vif.sel_dir_dirty_i  = dw;
    vif.sel_dir_wback_i  = dw;
    vif.sel_dir_fetch_i  = 4'b0;
    vif.cfg_way_mask_i   = 4'hF;
    vif.updt_i           = 1'b0;
    vif.updt_way_i       = 4'b0;
    vif.updt_set_i       = 6'd0;
  endtask

  initial begin
    rst_ni = 1'b0;
    set_req(1'b0, 2'd1, 0, 4'hF, 4'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst:valid", 32'(vif.sel_valid_o), 32'd0);
    check("rst:way",   32'(vif.sel_victim_way_o), 32'd0);
    check("rst:none",  32'(vif.sel_none_o), 32'd0);
    rst_ni = 1'b1;

    set_req(1'b1, 2'd1, 3, 4'b1011, 4'h0);
    cycle("t1");
    check("t1:lit", 32'(last_way), 32'h4);

    set_req(1'b0, 2'd1, 0, 4'hF, 4'h0);
    vif.updt_i = 1'b1;
    vif.updt_set_i = 6'd5;
    for (int w = 0; w < 3; w++) begin
      vif.updt_way_i = 4'(1 << w);
      cycle("t2u");
    end
    set_req(1'b1, 2'd1, 5, 4'hF, 4'h0);
    cycle("t2a");
    check("t2a:lit", 32'(last_way), 32'h8);
    cycle("t2b");
    check("t2b:lit", 32'(last_way), 32'h1);

    set_req(1'b1, 2'd2, 0, 4'hF, 4'h0);
    for (int k = 0; k < 5; k++) begin
      cycle("t3");
      check("t3:lit", 32'(last_way), 32'(1 << (k % 4)));
    end

    set_req(1'b1, 2'd2, 0, 4'hF, 4'h0);
    vif.cfg_way_mask_i  = 4'b0011;
    vif.sel_dir_fetch_i = 4'b0011;
    cycle("t4");
    check("t4:none", 32'(last_none), 32'd1);
    check("t4:way0", 32'(last_way), 32'd0);
    set_req(1'b1, 2'd2, 0, 4'hF, 4'h0);
    cycle("t4rr");
    check("t4rr:lit", 32'(last_way), 32'h2);

    set_req(1'b1, 2'd0, 9, 4'hF, 4'b1110);
    for (int k = 0; k < 4; k++) begin
      cycle("t5");
      check("t5:lit", 32'(last_way), 32'h1);
    end

    for (int w = 0; w < 4; w++) way_cnt[w] = 0;
    set_req(1'b1, 2'd0, 7, 4'hF, 4'h0);
    for (int k = 0; k < 1000; k++) begin
      vif.sel_victim_set_i = 6'($urandom_range(0, 63));
      cycle("t6");
      for (int w = 0; w < 4; w++) if (last_way[w]) way_cnt[w]++;
    end
    for (int w = 0; w < 4; w++) check("t6:spread", 32'(way_cnt[w] >= 150), 32'd1);

    set_req(1'b1, 2'd0, 1, 4'hF, 4'h0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_mid:valid", 32'(vif.sel_valid_o), 32'd0);
    vif.sel_victim_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel:valid", 32'(vif.sel_valid_o), 32'd0);
    set_req(1'b1, 2'd0, 1, 4'hF, 4'h0);
    cycle("t6seed");
    check("t6seed:lit", 32'(last_way), 32'h2);

    for (int k = 0; k < 2000; k++) begin
      vif.sel_victim_i     = ($urandom_range(0, 3) != 0);
      vif.cfg_mode_i       = 2'($urandom_range(0, 3));
      vif.cfg_way_mask_i   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      vif.sel_dir_valid_i  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      vif.sel_dir_dirty_i  = 4'($urandom);
      vif.sel_dir_wback_i  = 4'($urandom);
      vif.sel_dir_fetch_i  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      vif.sel_victim_set_i = 6'($urandom_range(0, 3));
      vif.updt_i           = $urandom_range(0, 1) == 1;
      vif.updt_set_i       = 6'($urandom_range(0, 3));
      vif.updt_way_i       = 4'($urandom);
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
